// File: rtl/system_halt_pkg.sv
// Shared constants and types for the system halt sequencer: register map,
// control/edge bit positions and the run/halt state encoding.
package system_halt_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 3;
    localparam int unsigned EDGE_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_EDGE    = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_TIMEOUT = 2'd3;

    localparam int unsigned CTRL_SW_HALT = 8;
    localparam int unsigned CTRL_RESUME  = 9;

    localparam int unsigned EDGE_DB_RISE = 0;
    localparam int unsigned EDGE_TIMEOUT = 1;
    localparam int unsigned EDGE_HALTED  = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_RESUME = 2'd3
    } halt_state_t;

    // STATUS register payload, LSB first: state, halt_db, halt_sync, timeout_flag
    typedef struct packed {
        logic        timeout_flag;
        logic        halt_sync;
        logic        halt_db;
        halt_state_t state;
    } status_t;

endpackage

// File: rtl/halt_debouncer.sv
// Two-flop synchroniser plus debounce filter for a slow asynchronous level
// input; also emits a one-cycle pulse when the debounced level rises.
module halt_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic din_sync,
    output logic din_db,
    output logic din_rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             din_meta;
    logic [CNT_W-1:0] stable_cnt;

    // Counter only runs while the synchronised level disagrees with the
    // filtered one; any return to agreement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_meta   <= 1'b0;
            din_sync   <= 1'b0;
            din_db     <= 1'b0;
            din_rise   <= 1'b0;
            stable_cnt <= '0;
        end else begin
            din_meta <= din;
            din_sync <= din_meta;
            din_rise <= 1'b0;
            if (din_sync == din_db) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                stable_cnt <= '0;
                din_db     <= din_sync;
                din_rise   <= din_sync;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/system_halt_sequencer.sv
// Avalon-MM run/halt/resume controller: conditions the external halt input,
// runs the halt request/acknowledge handshake and raises edge-capture IRQs.
module system_halt_sequencer
    import system_halt_pkg::*;
#(
    parameter int unsigned     DEBOUNCE_CYCLES = 1000,
    parameter int unsigned     TO_W            = 16,
    parameter logic [TO_W-1:0] TIMEOUT_DEFAULT = TO_W'(16'hFFFF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    input  logic              halt_in,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic              halted
);

    halt_state_t       state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [TO_W-1:0]   timeout_q;
    logic [MASK_W-1:0] mask_q;
    logic [EDGE_W-1:0] edge_q, edge_set, edge_clr;
    logic              timeout_flag_q, timeout_flag_d;
    logic              halt_req_d, halted_d;
    logic              halt_sync, halt_db, halt_db_rise;
    logic              wr_ctrl, wr_edge, wr_timeout;
    logic              sw_halt, sw_resume, trigger;
    logic [DATA_W-1:0] rdata_d;
    status_t           status;
    logic              unused_wdata;

    halt_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .din      (halt_in),
        .din_sync (halt_sync),
        .din_db   (halt_db),
        .din_rise (halt_db_rise)
    );

    assign wr_ctrl      = write && (address == ADDR_CONTROL);
    assign wr_edge      = write && (address == ADDR_EDGE);
    assign wr_timeout   = write && (address == ADDR_TIMEOUT);
    assign sw_halt      = wr_ctrl && writedata[CTRL_SW_HALT];
    assign sw_resume    = wr_ctrl && writedata[CTRL_RESUME];
    assign trigger      = halt_db_rise || sw_halt;
    assign unused_wdata = ^writedata;

    // Next-state logic; outputs are derived from the next state so they
    // register in step with the state itself.
    always_comb begin
        state_d        = state_q;
        to_cnt_d       = to_cnt_q;
        timeout_flag_d = timeout_flag_q;
        edge_set       = '0;
        edge_set[EDGE_DB_RISE] = halt_db_rise;

        case (state_q)
            ST_RUN: begin
                if (trigger) begin
                    state_d  = ST_DRAIN;
                    to_cnt_d = timeout_q;
                end
            end
            ST_DRAIN: begin
                to_cnt_d = to_cnt_q - TO_W'(1);
                if (halt_ack) begin
                    state_d = ST_HALTED;
                end else if (to_cnt_q == '0) begin
                    state_d                = ST_HALTED;
                    timeout_flag_d         = 1'b1;
                    edge_set[EDGE_TIMEOUT] = 1'b1;
                end
            end
            ST_HALTED: begin
                if (sw_resume && !halt_db) begin
                    state_d        = ST_RESUME;
                    timeout_flag_d = 1'b0;
                end
            end
            ST_RESUME: begin
                timeout_flag_d = 1'b0;
                if (!halt_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if ((state_d == ST_HALTED) && (state_q != ST_HALTED)) begin
            edge_set[EDGE_HALTED] = 1'b1;
        end

        halt_req_d = (state_d == ST_DRAIN) || (state_d == ST_HALTED);
        halted_d   = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            to_cnt_q       <= '0;
            timeout_flag_q <= 1'b0;
            halt_req       <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state_q        <= state_d;
            to_cnt_q       <= to_cnt_d;
            timeout_flag_q <= timeout_flag_d;
            halt_req       <= halt_req_d;
            halted         <= halted_d;
        end
    end

    assign edge_clr = wr_edge ? writedata[EDGE_W-1:0] : '0;

    always_comb begin
        status = '{timeout_flag: timeout_flag_q, halt_sync: halt_sync,
                   halt_db: halt_db, state: state_q};
        rdata_d = '0;
        case (address)
            ADDR_STATUS:  rdata_d = DATA_W'(status);
            ADDR_CONTROL: rdata_d = DATA_W'(mask_q);
            ADDR_EDGE:    rdata_d = DATA_W'(edge_q);
            ADDR_TIMEOUT: rdata_d = DATA_W'(timeout_q);
            default:      rdata_d = '0;
        endcase
    end

    // Register file, read port and interrupt; edge set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q    <= '0;
            edge_q    <= '0;
            timeout_q <= TIMEOUT_DEFAULT;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                mask_q <= writedata[MASK_W-1:0];
            end
            if (wr_timeout) begin
                timeout_q <= writedata[TO_W-1:0];
            end
            edge_q   <= (edge_q & ~edge_clr) | edge_set;
            readdata <= rdata_d;
            irq      <= |(edge_q & mask_q);
        end
    end

endmodule
